// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and opcode definitions for the two-port shared-ALU arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_share_arbiter_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // One operation presented to the shared ALU.
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [2:0]       op;
    } alu_req_t;

    // ALU result plus the flags captured into each response buffer.
    typedef struct packed {
        logic [ALU_W-1:0] z;
        logic             zero;
        logic             err;
    } alu_rsp_t;

    // True for opcodes the ALU implements; anything else yields 0 with err set.
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Shared 32-bit ALU (AND/OR/ADD/SUB/SLT-unsigned) with zero and illegal-op flags.
// Latency: purely combinational, result valid in the same cycle as the operands.
// Backpressure: none; the arbiter decides when the result is captured.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  alu_req_t req,
    output alu_rsp_t rsp
);

    logic [ALU_W-1:0] z;

    // Function select; unknown opcodes produce 0. The carry/overflow side
    // output of the original ALU is always 0, so it is not modelled here.
    always_comb begin
        z = '0;
        case (req.op)
            OP_AND:  z = req.a & req.b;
            OP_OR:   z = req.a | req.b;
            OP_ADD:  z = req.a + req.b;
            OP_SUB:  z = req.a - req.b;
            OP_SLT:  z = {{(ALU_W-1){1'b0}}, (req.a < req.b)};
            default: z = '0;
        endcase
    end

    // Flags travel with the result into the response buffer.
    always_comb begin
        rsp.z    = z;
        rsp.zero = (z == '0);
        rsp.err  = !is_legal_op(req.op);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters with one-entry response buffers.
// Latency: op accepted at edge N, response visible right after edge N.
// Backpressure: a port is not accepted while its full buffer is not being drained.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [2:0]       req_op0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [2:0]       req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_z0,
    output logic [WIDTH-1:0] rsp_z1,
    output logic [1:0]       rsp_zero,
    output logic [1:0]       rsp_err,
    output logic [CNT_W-1:0] acc_cnt0,
    output logic [CNT_W-1:0] acc_cnt1,
    output logic             last_grant
);

    logic [1:0] can_take;
    logic [1:0] elig;
    logic [1:0] grant;
    alu_req_t   alu_req;
    alu_rsp_t   alu_rsp;

    // A buffer accepts a new result when empty or being drained this cycle.
    // Nothing is granted while reset is held so req_ready stays low.
    always_comb begin
        can_take = ~rsp_valid | rsp_ready;
        elig     = req_valid & can_take & {2{resetn}};
    end

    // Round-robin: on contention the port that was not granted last wins.
    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
        req_ready = grant;
    end

    // Steer the granted port's operands into the single ALU instance.
    always_comb begin
        if (grant[1]) begin
            alu_req = '{a: req_a1, b: req_b1, op: req_op1};
        end else begin
            alu_req = '{a: req_a0, b: req_b0, op: req_op0};
        end
    end

    alu_share_arbiter_alu u_alu (
        .req (alu_req),
        .rsp (alu_rsp)
    );

    // Port 0 response buffer and accept counter; refill takes precedence over pop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_valid[0] <= 1'b0;
            rsp_z0       <= '0;
            rsp_zero[0]  <= 1'b0;
            rsp_err[0]   <= 1'b0;
            acc_cnt0     <= '0;
        end else if (grant[0]) begin
            rsp_valid[0] <= 1'b1;
            rsp_z0       <= alu_rsp.z;
            rsp_zero[0]  <= alu_rsp.zero;
            rsp_err[0]   <= alu_rsp.err;
            acc_cnt0     <= acc_cnt0 + CNT_W'(1);
        end else if (rsp_ready[0]) begin
            rsp_valid[0] <= 1'b0;
        end
    end

    // Port 1 response buffer and accept counter; refill takes precedence over pop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_valid[1] <= 1'b0;
            rsp_z1       <= '0;
            rsp_zero[1]  <= 1'b0;
            rsp_err[1]   <= 1'b0;
            acc_cnt1     <= '0;
        end else if (grant[1]) begin
            rsp_valid[1] <= 1'b1;
            rsp_z1       <= alu_rsp.z;
            rsp_zero[1]  <= alu_rsp.zero;
            rsp_err[1]   <= alu_rsp.err;
            acc_cnt1     <= acc_cnt1 + CNT_W'(1);
        end else if (rsp_ready[1]) begin
            rsp_valid[1] <= 1'b0;
        end
    end

    // Round-robin pointer: remembers the last granted port, held on idle cycles.
    // Reset to 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (grant[1]) begin
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            last_grant <= 1'b0;
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 32-bit ALU (yAlu function set) between two requesters (port 0, port 1). Uses a valid/ready request handshake and round-robin grant. Each requester has a one-entry registered response buffer holding the result, a zero flag and an illegal-op flag. Sits between two datapath clients and a single yAlu instance, so only one ALU is built in the design.

Parameters:
- WIDTH, 32, operand/result width; fixed at 32 to match yAlu, other values unsupported.
- CNT_W, 16, width of per-port accepted-operation counters.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous, active-low reset
- req_valid  input  2  bit i: port i presents an operation
- req_ready  output  2  bit i: port i operation accepted this cycle (valid&ready)
- req_a0, req_b0  input  32 each  port 0 operands
- req_op0  input  3  port 0 opcode
- req_a1, req_b1  input  32 each  port 1 operands
- req_op1  input  3  port 1 opcode
- rsp_valid  output  2  bit i: port i response buffer full
- rsp_ready  input  2  bit i: port i consumes response
- rsp_z0, rsp_z1  output  32 each  registered ALU results
- rsp_zero  output  2  bit i: rsp_zi == 0
- rsp_err  output  2  bit i: opcode was not 000/001/010/110/111
- acc_cnt0, acc_cnt1  output  CNT_W each  accepted-op counters, wrapping
- last_grant  output  1  port granted most recently (round-robin pointer)

Behaviour:
- Reset (resetn=0 at a posedge): rsp_valid=0, rsp_z0/1=0, rsp_zero=0, rsp_err=0, acc_cnt0/1=0, last_grant=1 (port 0 has priority first). A reset mid-operation discards buffered responses; any in-flight accept is lost.
- Eligibility: port i is eligible when req_valid[i]=1 and its buffer can take a result. A buffer can take a result when rsp_valid[i]=0, or when rsp_valid[i]=1 and rsp_ready[i]=1 in the same cycle (same-cycle drain and refill).
- Grant is combinational, at most one port per cycle.
  - Only one port eligible: that port is granted.
  - Both eligible: grant the port != last_grant.
  - req_ready[i] = grant[i]. req_ready never asserts for a non-valid port.
- The granted port's a/b/op are muxed into the shared ALU in the same cycle.
- ALU semantics (32-bit):
  - 000 → a&b
  - 001 → a|b
  - 010 → a+b (carry discarded)
  - 110 → a−b (two's complement, wraps)
  - 111 → 1 if a<b unsigned, else 0
  - any other opcode → 0 with err=1
- On grant to port i at the edge:
  - rsp_zi ← z; rsp_zero[i] ← (z==0); rsp_err[i] ← illegal; rsp_valid[i] ← 1
  - acc_cnti increments, wrapping to 0 from 2^CNT_W−1
  - last_grant ← i
- Latency: accept at edge N, response visible after edge N. One op per cycle total throughput. Each port sustains one op per cycle while alone and rsp_ready held high.
- Response pop: rsp_valid[i]=1 and rsp_ready[i]=1 with no refill → rsp_valid[i] ← 0. Data registers hold their last value.
- Response hold: rsp_valid[i]=1 and rsp_ready[i]=0 → buffer contents stay stable and req_ready[i]=0 (backpressure).
- No grant in a cycle → last_grant unchanged.
- Inputs of a non-granted port are ignored. Requesters must hold req_* stable while valid and not ready.
- ex from the ALU is constant 0 and unused.

Decomposition:
- Shared package/header holds:
  - opcode constants: OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111
  - an is_legal_op function
- Natural sub-module: instantiate yAlu for the datapath.
  - rsp_zero is computed in this block.
  - Illegal-op detection is done in this block from the opcode.
- Round-robin grant logic stays inline; no separate sub-module.

Test Plan:
- Reset: assert resetn=0 for 2 cycles with req_valid=2'b11 → req_ready=0 during reset; all outputs 0 except last_grant=1.
- Single port ALU ops: port 0, op 010, a=32'hFFFFFFFF, b=1, rsp_ready=1 → next cycle rsp_z0=0, rsp_zero[0]=1, acc_cnt0=1. Then op 110 with a=3, b=5 → rsp_z0=32'hFFFFFFFE. Then op 111 with a=3, b=5 → rsp_z0=1.
- Contention: both ports valid continuously, rsp_ready=2'b11 → grants alternate 0,1,0,1. After 8 cycles acc_cnt0=acc_cnt1=4.
- Backpressure: port 1 result pending with rsp_ready[1]=0 for 3 cycles → req_ready[1]=0 and rsp_z1 stable throughout; port 0 is granted every cycle. Raising rsp_ready[1] → same-cycle pop plus new accept.
- Illegal op: port 1 op 011, a=7, b=9 → rsp_z1=0, rsp_err[1]=1, rsp_zero[1]=1.
- Reset mid-flight: accept on port 0, then resetn=0 before pop → rsp_valid=0 and acc_cnt0=0 after the edge.
